axi_txn_guard: RTL and testbench



---
 rtl/axi_guard_pkg.sv | 14 +
 rtl/axi_pkg.sv | 10 +
 rtl/axi_txn_counter.sv | 38 +++
 rtl/axi_txn_guard.sv | 136 +++++++++++++
 tb/tb_axi_txn_guard.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_guard_pkg.sv
// Shared types and defaults for the AXI transaction guard.
// Error records carry an ID sized for the widest supported master.
package axi_guard_pkg;

    localparam int unsigned MAX_TXN_DEFAULT = 8;
    localparam int unsigned ID_W_MAX        = 16;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic                write;
        logic [1:0]          resp;
    } err_info_t;

endpackage

// File: rtl/axi_pkg.sv
// AXI protocol constants shared across the SoC.
// Only the response encodings are needed by the transaction guard.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_txn_counter.sv
// Saturating outstanding-transaction counter with full and underflow flags.
// Increments are expected to be gated by full upstream.
module axi_txn_counter #(
    parameter  int unsigned MaxTxn = 8,
    localparam int unsigned CntW   = $clog2(MaxTxn + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            underflow_o
);

    localparam logic [CntW-1:0] FULL = CntW'(MaxTxn);

    logic [CntW-1:0] r_count;
    logic            w_full;
    logic            w_empty;

    assign w_full      = (r_count == FULL);
    assign w_empty     = (r_count == '0);
    assign underflow_o = dec_i & ~inc_i & w_empty;
    assign full_o      = w_full;
    assign count_o     = r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (inc_i & ~dec_i & ~w_full) begin
            r_count <= r_count + CntW'(1);
        end else if (dec_i & ~inc_i & ~w_empty) begin
            r_count <= r_count - CntW'(1);
        end
    end

endmodule

// File: rtl/axi_txn_guard.sv
// Throttles AW/AR toward the CDC source and records AXI error responses.
// Status outputs are registered; address gates are combinational on counts.
module axi_txn_guard
    import axi_pkg::*;
    import axi_guard_pkg::*;
#(
    parameter int unsigned MaxTxn      = MAX_TXN_DEFAULT,
    parameter int unsigned IdWidth     = 5,
    parameter int unsigned ErrCntWidth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         aw_valid_i,
    output logic                         aw_ready_o,
    output logic                         aw_valid_o,
    input  logic                         aw_ready_i,
    input  logic                         ar_valid_i,
    output logic                         ar_ready_o,
    output logic                         ar_valid_o,
    input  logic                         ar_ready_i,
    input  logic                         r_valid_i,
    input  logic                         r_ready_i,
    input  logic                         r_last_i,
    input  logic [1:0]                   r_resp_i,
    input  logic [IdWidth-1:0]           r_id_i,
    input  logic                         b_valid_i,
    input  logic                         b_ready_i,
    input  logic [1:0]                   b_resp_i,
    input  logic [IdWidth-1:0]           b_id_i,
    input  logic                         err_clear_i,
    output logic [$clog2(MaxTxn+1)-1:0]  wr_outstanding_o,
    output logic [$clog2(MaxTxn+1)-1:0]  rd_outstanding_o,
    output logic [ErrCntWidth-1:0]       err_cnt_o,
    output logic                         err_sticky_o,
    output logic [IdWidth-1:0]           err_id_o,
    output logic                         err_write_o,
    output logic [1:0]                   err_resp_o,
    output logic                         proto_err_o
);

    logic w_wr_full, w_rd_full;
    logic w_wr_uf, w_rd_uf;
    logic w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;

    assign aw_valid_o = aw_valid_i & ~w_wr_full;
    assign aw_ready_o = aw_ready_i & ~w_wr_full;
    assign ar_valid_o = ar_valid_i & ~w_rd_full;
    assign ar_ready_o = ar_ready_i & ~w_rd_full;

    assign w_wr_inc = aw_valid_o & aw_ready_i;
    assign w_wr_dec = b_valid_i & b_ready_i;
    assign w_rd_inc = ar_valid_o & ar_ready_i;
    assign w_rd_dec = r_valid_i & r_ready_i & r_last_i;

    axi_txn_counter #(.MaxTxn(MaxTxn)) u_wr_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (w_wr_inc),
        .dec_i       (w_wr_dec),
        .count_o     (wr_outstanding_o),
        .full_o      (w_wr_full),
        .underflow_o (w_wr_uf)
    );

    axi_txn_counter #(.MaxTxn(MaxTxn)) u_rd_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (w_rd_inc),
        .dec_i       (w_rd_dec),
        .count_o     (rd_outstanding_o),
        .full_o      (w_rd_full),
        .underflow_o (w_rd_uf)
    );

    logic                   w_r_err, w_b_err;
    logic [1:0]             w_n_err;
    logic [ErrCntWidth-1:0] w_cnt_base;
    logic [ErrCntWidth:0]   w_cnt_sum;
    logic [ErrCntWidth-1:0] w_cnt_nxt;
    err_info_t              w_new;

    logic [ErrCntWidth-1:0] r_err_cnt;
    logic                   r_sticky;
    logic                   r_proto;
    err_info_t              r_info;

    assign w_r_err = r_valid_i & r_ready_i &
                     ((r_resp_i == RESP_SLVERR) | (r_resp_i == RESP_DECERR));
    assign w_b_err = b_valid_i & b_ready_i &
                     ((b_resp_i == RESP_SLVERR) | (b_resp_i == RESP_DECERR));
    assign w_n_err = {1'b0, w_r_err} + {1'b0, w_b_err};

    always_comb begin
        w_cnt_base = err_clear_i ? '0 : r_err_cnt;
        w_cnt_sum  = {1'b0, w_cnt_base} + (ErrCntWidth+1)'(w_n_err);
        w_cnt_nxt  = w_cnt_sum[ErrCntWidth] ? '1 : w_cnt_sum[ErrCntWidth-1:0];
        // B wins a same-cycle tie with R
        w_new.id    = w_b_err ? ID_W_MAX'(b_id_i) : ID_W_MAX'(r_id_i);
        w_new.write = w_b_err;
        w_new.resp  = w_b_err ? b_resp_i : r_resp_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
            r_sticky  <= 1'b0;
            r_info    <= '0;
            r_proto   <= 1'b0;
        end else begin
            r_err_cnt <= w_cnt_nxt;
            if ((w_r_err | w_b_err) & (~r_sticky | err_clear_i)) begin
                r_info   <= w_new;
                r_sticky <= 1'b1;
            end else if (err_clear_i) begin
                r_info   <= '0;
                r_sticky <= 1'b0;
            end
            if (w_wr_uf | w_rd_uf) begin
                r_proto <= 1'b1;
            end else if (err_clear_i) begin
                r_proto <= 1'b0;
            end
        end
    end

    logic w_unused_id;
    assign w_unused_id = ^r_info.id;

    assign err_cnt_o    = r_err_cnt;
    assign err_sticky_o = r_sticky;
    assign err_id_o     = r_info.id[IdWidth-1:0];
    assign err_write_o  = r_info.write;
    assign err_resp_o   = r_info.resp;
    assign proto_err_o  = r_proto;

endmodule

// File: tb/tb_axi_txn_guard.sv
// Directed and random checks of axi_txn_guard against a transaction-level model.
module tb_axi_txn_guard;

    localparam int MAX = 2;
    localparam int IDW = 5;
    localparam int ECW = 3;
    localparam int ESAT = (1 << ECW) - 1;
    localparam int CW = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic aw_valid_i = 0, aw_ready_i = 0, ar_valid_i = 0, ar_ready_i = 0;
    logic aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o;
    logic r_valid_i = 0, r_ready_i = 0, r_last_i = 0;
    logic [1:0] r_resp_i = 0, b_resp_i = 0;
    logic [IDW-1:0] r_id_i = 0, b_id_i = 0;
    logic b_valid_i = 0, b_ready_i = 0, err_clear_i = 0;
    logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;
    logic [ECW-1:0] err_cnt_o;
    logic err_sticky_o, err_write_o, proto_err_o;
    logic [IDW-1:0] err_id_o;
    logic [1:0] err_resp_o;

    always #5 clk = ~clk;

    axi_txn_guard #(.MaxTxn(MAX), .IdWidth(IDW), .ErrCntWidth(ECW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .r_resp_i(r_resp_i), .r_id_i(r_id_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .b_resp_i(b_resp_i), .b_id_i(b_id_i),
        .err_clear_i(err_clear_i),
        .wr_outstanding_o(wr_outstanding_o),
        .rd_outstanding_o(rd_outstanding_o),
        .err_cnt_o(err_cnt_o), .err_sticky_o(err_sticky_o),
        .err_id_o(err_id_o), .err_write_o(err_write_o),
        .err_resp_o(err_resp_o), .proto_err_o(proto_err_o)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    int wr_m = 0, rd_m = 0, ecnt_m = 0, id_m = 0, resp_m = 0;
    bit sticky_m = 0, write_m = 0, proto_m = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    task automatic idle();
        aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
        r_valid_i = 0; r_ready_i = 0; r_last_i = 0; r_resp_i = 0; r_id_i = 0;
        b_valid_i = 0; b_ready_i = 0; b_resp_i = 0; b_id_i = 0;
        err_clear_i = 0;
    endtask

    // Called at a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        bit wr_inc, wr_dec, rd_inc, rd_dec, re, be, uf;
        int n;
        #1;
        check("aw_valid_o", aw_valid_o, aw_valid_i && wr_m != MAX);
        check("aw_ready_o", aw_ready_o, aw_ready_i && wr_m != MAX);
        check("ar_valid_o", ar_valid_o, ar_valid_i && rd_m != MAX);
        check("ar_ready_o", ar_ready_o, ar_ready_i && rd_m != MAX);
        wr_inc = aw_valid_i && aw_ready_i && wr_m != MAX;
        wr_dec = b_valid_i && b_ready_i;
        rd_inc = ar_valid_i && ar_ready_i && rd_m != MAX;
        rd_dec = r_valid_i && r_ready_i && r_last_i;
        re = r_valid_i && r_ready_i && r_resp_i >= 2;
        be = b_valid_i && b_ready_i && b_resp_i >= 2;
        @(posedge clk);
        if (rst_i) begin
            wr_m = 0; rd_m = 0; ecnt_m = 0; id_m = 0; resp_m = 0;
            sticky_m = 0; write_m = 0; proto_m = 0;
        end else begin
            uf = 0;
            if (wr_dec && !wr_inc && wr_m == 0) uf = 1;
            else wr_m = wr_m + int'(wr_inc) - int'(wr_dec);
            if (rd_dec && !rd_inc && rd_m == 0) uf = 1;
            else rd_m = rd_m + int'(rd_inc) - int'(rd_dec);
            if (err_clear_i) begin
                ecnt_m = 0; sticky_m = 0; id_m = 0; write_m = 0; resp_m = 0;
                proto_m = 0;
            end
            if (uf) proto_m = 1;
            n = int'(re) + int'(be);
            ecnt_m = (ecnt_m + n > ESAT) ? ESAT : ecnt_m + n;
            if (n > 0 && !sticky_m) begin
                sticky_m = 1;
                write_m = be;
                id_m = be ? int'(b_id_i) : int'(r_id_i);
                resp_m = be ? int'(b_resp_i) : int'(r_resp_i);
            end
        end
        #1;
        check("wr_outstanding", wr_outstanding_o, wr_m);
        check("rd_outstanding", rd_outstanding_o, rd_m);
        check("err_cnt", err_cnt_o, ecnt_m);
        check("err_sticky", err_sticky_o, sticky_m);
        check("err_id", err_id_o, id_m);
        check("err_write", err_write_o, write_m);
        check("err_resp", err_resp_o, resp_m);
        check("proto_err", proto_err_o, proto_m);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_i = 1;
        @(posedge clk);
        @(negedge clk);
        // Gates open during reset
        aw_valid_i = 1; aw_ready_i = 1;
        #1;
        check("rst_gate_open", aw_valid_o, 1);
        step();
        check("rst_wr_zero", wr_outstanding_o, 0);
        check("rst_err_cnt_zero", err_cnt_o, 0);
        rst_i = 0;

        // Full throttle: two AW pass, third blocked
        idle();
        aw_valid_i = 1; aw_ready_i = 1;
        step(); step(); step();
        #1;
        check("full_aw_valid", aw_valid_o, 0);
        check("full_aw_ready", aw_ready_o, 0);
        check("full_wr_cnt", wr_outstanding_o, 2);
        b_valid_i = 1; b_ready_i = 1;
        step();
        b_valid_i = 0; b_ready_i = 0;
        #1;
        check("bubble_then_open", aw_valid_o, 1);
        step();
        check("third_aw_passed", wr_outstanding_o, 2);
        idle();

        // AR and R-last together at count 1
        ar_valid_i = 1; ar_ready_i = 1;
        step();
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1;
        step();
        check("ar_rlast_same", rd_outstanding_o, 1);
        idle();
        r_valid_i = 1; r_ready_i = 1;
        for (int b = 0; b < 4; b++) begin
            r_last_i = (b == 3);
            step();
            check("burst_beat", rd_outstanding_o, (b == 3) ? 0 : 1);
        end
        idle();

        // Simultaneous R DECERR and B SLVERR: B captured
        r_valid_i = 1; r_ready_i = 1; r_resp_i = 2'b11; r_id_i = 3;
        b_valid_i = 1; b_ready_i = 1; b_resp_i = 2'b10; b_id_i = 7;
        step();
        check("dual_err_cnt", err_cnt_o, 2);
        check("dual_err_id", err_id_o, 7);
        check("dual_err_write", err_write_o, 1);
        check("dual_err_resp", err_resp_o, 2'b10);
        idle();

        // Clear colliding with a new R SLVERR
        err_clear_i = 1;
        r_valid_i = 1; r_ready_i = 1; r_resp_i = 2'b10; r_id_i = 1;
        step();
        check("clr_coll_cnt", err_cnt_o, 1);
        check("clr_coll_id", err_id_o, 1);
        check("clr_coll_sticky", err_sticky_o, 1);
        err_clear_i = 0;

        // Counter saturation
        r_resp_i = 2'b11; r_id_i = 9;
        for (int i = 0; i < 8; i++) step();
        check("err_cnt_sat", err_cnt_o, ESAT);
        check("sticky_holds_id", err_id_o, 1);
        idle();

        // Drain writes then underflow on B
        err_clear_i = 1;
        step();
        idle();
        b_valid_i = 1; b_ready_i = 1;
        while (wr_m > 0) step();
        step();
        check("uf_proto", proto_err_o, 1);
        check("uf_wr_zero", wr_outstanding_o, 0);
        idle();

        // Reset with two reads outstanding
        ar_valid_i = 1; ar_ready_i = 1;
        step(); step();
        check("two_reads", rd_outstanding_o, 2);
        idle();
        rst_i = 1;
        step();
        check("rst_rd_zero", rd_outstanding_o, 0);
        check("rst_proto_zero", proto_err_o, 0);
        check("rst_sticky_zero", err_sticky_o, 0);
        rst_i = 0;

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst_i       = ($urandom_range(0, 99) == 0);
            err_clear_i = ($urandom_range(0, 15) == 0);
            aw_valid_i  = $urandom_range(0, 1) != 0;
            aw_ready_i  = $urandom_range(0, 1) != 0;
            ar_valid_i  = $urandom_range(0, 1) != 0;
            ar_ready_i  = $urandom_range(0, 1) != 0;
            r_valid_i   = $urandom_range(0, 1) != 0;
            r_ready_i   = $urandom_range(0, 3) != 0;
            r_last_i    = $urandom_range(0, 2) == 0;
            r_resp_i    = 2'($urandom_range(0, 3));
            r_id_i      = IDW'($urandom);
            b_valid_i   = $urandom_range(0, 2) == 0;
            b_ready_i   = $urandom_range(0, 3) != 0;
            b_resp_i    = 2'($urandom_range(0, 3));
            b_id_i      = IDW'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
